data_mem_responder: RTL

- Slave (responder) end of the core's external data-memory handshake (daddr, ddata_w, WRam, RRam -> ddata_r, done_ext).
- Accepts one read or write request at a time and holds it for a programmable access latency.
- Commits the access to an internal word array and returns a one-cycle done_ext pulse, with read data when applicable.
- Used as the bench/FPGA data memory behind the pipeline's read/write control logic.

---
 rtl/data_mem_responder.sv | 106 ++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one read/write request, holds it for
// LATENCY edges, commits to a word array, then pulses done_ext (and err).
// Ports: CLK, RST (async high), daddr/ddata_w/WRam/RRam request in;
//        ddata_r read data, done_ext pulse, busy, err out.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] daddr,
  input  logic [31:0] ddata_w,
  input  logic        WRam,
  input  logic        RRam,
  output logic [31:0] ddata_r,
  output logic        done_ext,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic        dual_q;

  logic [31:0] mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  oor;
  logic                  commit;

  assign idx    = addr_q[DEPTH_LOG2+1:2];
  // any address bit above the array span makes the access invalid
  assign oor    = (addr_q >> (DEPTH_LOG2 + 2)) != 32'd0;
  assign commit = (state == WAIT) && (cnt == 4'd0);
  assign busy   = (state != IDLE);

  // array has no reset so it maps onto block RAM
  always_ff @(posedge CLK) begin
    if (commit && wr_q && !oor) begin
      mem[idx] <= wdata_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wr_q     <= 1'b0;
      dual_q   <= 1'b0;
      ddata_r  <= 32'd0;
      done_ext <= 1'b0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_ext <= 1'b0;
          err      <= 1'b0;
          if (RRam || WRam) begin
            addr_q  <= daddr;
            wdata_q <= ddata_w;
            wr_q    <= WRam;
            dual_q  <= WRam && RRam;
            cnt     <= CNT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!wr_q) begin
              ddata_r <= oor ? 32'd0 : mem[idx];
            end
            done_ext <= 1'b1;
            err      <= oor || dual_q;
            state    <= RESP;
          end
        end
        RESP: begin
          done_ext <= 1'b0;
          err      <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          done_ext <= 1'b0;
          err      <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
